// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// muldiv_unit: E-stage multi-cycle multiply/divide unit that owns HI/LO.
// Busy feeds the hazard unit; HI/LO feed the E-stage result mux for mfhi/mflo.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [2:0]       r_op;
    logic [31:0]      r_a, r_b, r_hi, r_lo;

    logic        w_is_md, w_go, w_launch, w_done;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_div_a, w_div_b, w_den, w_q_mag, w_r_mag, w_quot, w_rem;
    logic [63:0] w_prod_s, w_prod_u;

    assign w_is_md  = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
    assign w_go     = Start & ~Req & (r_cnt == CNT_ZERO) & (MDOp != OP_NONE);
    assign w_launch = w_go & w_is_md;
    assign w_done   = (r_state == S_RUN) && (r_cnt == CNT_ONE);

    // Busy drops in the cycle before the write edge: an mfhi/mflo released
    // then reaches E only after HI/LO have been updated.
    assign Busy = (Start & ~Req & w_is_md) | (r_cnt > CNT_ONE);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_next = S_RUN;
                    w_cnt_next   = (MDOp >= OP_DIV) ? CNT_DIV : CNT_MULT;
                end
            end
            S_RUN: begin
                w_cnt_next = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE)
                    w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op <= OP_NONE;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_launch) begin
            r_op <= MDOp;
            r_a  <= A;
            r_b  <= B;
        end
    end

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
    assign w_a_neg  = (r_op == OP_DIV) & r_a[31];
    assign w_b_neg  = (r_op == OP_DIV) & r_b[31];
    assign w_div_a  = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_div_b  = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_den    = (w_div_b == 32'd0) ? 32'd1 : w_div_b;
    assign w_q_mag  = w_div_a / w_den;
    assign w_r_mag  = w_div_a % w_den;
    assign w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem    = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            case (r_op)
                OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                OP_DIV, OP_DIVU: begin
                    if (r_b != 32'd0) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end else if (w_go && (MDOp == OP_MTHI)) begin
            r_hi <= A;
        end else if (w_go && (MDOp == OP_MTLO)) begin
            r_lo <= A;
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// tb_muldiv_unit: table-driven directed vectors plus hand sequences for
// reset abort and an ignored Start during a running divide.
module tb_muldiv_unit;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int NVEC = 15;

    typedef struct {
        logic [2:0]  op;
        logic        req;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  MDOp = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Req = 1'b0;
    logic        Busy;
    logic [31:0] HI, LO;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;
    vec_t        vecs[NVEC];

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
        .A(A), .B(B), .Req(Req), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nb;
        int guard;
        @(negedge clk);
        Start = 1'b1; MDOp = v.op; A = v.a; B = v.b; Req = v.req;
        #1;
        check($sformatf("v%0d busy_start", idx), 32'(Busy), 32'(v.cyc != 0));
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0; A = 32'hDEADBEEF; B = 32'd0; Req = 1'b0;
        #1;
        nb = (v.cyc != 0) ? 1 : 0;
        guard = 0;
        while (Busy && guard < 40) begin
            nb++;
            guard++;
            @(negedge clk);
            #1;
        end
        check($sformatf("v%0d busy_len", idx), 32'(nb), 32'(v.cyc));
        if (v.cyc != 0) begin
            check($sformatf("v%0d hi_before_write", idx), HI, prev_hi);
            check($sformatf("v%0d lo_before_write", idx), LO, prev_lo);
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        check($sformatf("v%0d hi", idx), HI, v.hi);
        check($sformatf("v%0d lo", idx), LO, v.lo);
        $display("vec %0d op=%0d req=%0d A=%08h B=%08h -> HI=%08h LO=%08h busy=%0d",
                 idx, v.op, v.req, v.a, v.b, HI, LO, nb);
        prev_hi = v.hi;
        prev_lo = v.lo;
    endtask

    initial begin
        vecs[0]  = '{OP_MULT,  1'b0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{OP_MULTU, 1'b0, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{OP_DIV,   1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{OP_DIV,   1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[4]  = '{OP_DIVU,  1'b0, 32'h00000007, 32'h00000000, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{OP_MTLO,  1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h12345678, 0};
        vecs[6]  = '{OP_MTHI,  1'b1, 32'hCAFEF00D, 32'h00000000, 32'h00000000, 32'h12345678, 0};
        vecs[7]  = '{OP_MTHI,  1'b0, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D, 32'h12345678, 0};
        vecs[8]  = '{OP_MTLO,  1'b1, 32'h00000000, 32'h00000000, 32'hCAFEF00D, 32'h12345678, 0};
        vecs[9]  = '{OP_DIVU,  1'b0, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[10] = '{OP_DIV,   1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[11] = '{OP_MULT,  1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[12] = '{OP_MULTU, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[13] = '{OP_DIV,   1'b1, 32'd50,       32'd5,        32'hFFFFFFFE, 32'h00000001, 0};
        vecs[14] = '{OP_MULT,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};

        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset hi", HI, 32'd0);
        check("reset lo", LO, 32'd0);
        check("reset busy", 32'(Busy), 32'd0);
        $display("reset: HI=%08h LO=%08h Busy=%0d", HI, LO, Busy);

        for (int i = 0; i < NVEC; i++)
            run_vec(i, vecs[i]);

        // A second Start during a running divide must be ignored.
        @(negedge clk);
        Start = 1'b1; MDOp = OP_DIV; A = 32'd100; B = 32'd9; Req = 1'b0;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        @(negedge clk);
        Start = 1'b1; MDOp = OP_MULT; A = 32'd2; B = 32'd3;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        repeat (8) @(negedge clk);
        #1;
        check("ignored_start hi", HI, 32'h00000001);
        check("ignored_start lo", LO, 32'h0000000B);
        check("ignored_start busy", 32'(Busy), 32'd0);
        repeat (8) @(negedge clk);
        #1;
        check("ignored_start hi_later", HI, 32'h00000001);
        check("ignored_start lo_later", LO, 32'h0000000B);
        $display("ignored start: HI=%08h LO=%08h Busy=%0d", HI, LO, Busy);

        // Reset in the middle of a multiply aborts it with no later write.
        @(negedge clk);
        Start = 1'b1; MDOp = OP_MULT; A = 32'd5; B = 32'd7;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort hi", HI, 32'd0);
        check("abort lo", LO, 32'd0);
        check("abort busy", 32'(Busy), 32'd0);
        repeat (8) @(negedge clk);
        #1;
        check("abort hi_later", HI, 32'd0);
        check("abort lo_later", LO, 32'd0);
        check("abort busy_later", 32'(Busy), 32'd0);
        $display("reset abort: HI=%08h LO=%08h Busy=%0d", HI, LO, Busy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
